fmc_controller: RTL

- Multi-cycle sequencer for the RV32I-subset datapath.
- Fetches each instruction over an imem request/ack handshake into an internal instruction register (IR) and decodes it.
- Drives the datapath control inputs, sequences data-memory accesses over a dmem request/ack handshake, and gates PC update.
- Also provides a watchdog on both memory handshakes, a halt/trap state, and a retired-instruction counter.

---
 rtl/fmc_pkg.sv | 52 +++++
 rtl/fmc_decoder.sv | 72 +++++++
 rtl/fmc_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fmc_pkg.sv
// Shared constants and types for the multi-cycle RV32I-subset sequencer.
// Opcodes, 4-bit ALU encoding, FSM states and instruction classes.
package fmc_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic [2:0] {
        ST_BOOT, ST_FETCH, ST_EXEC, ST_MEM, ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP, CL_ILL
    } iclass_t;

    function automatic logic [3:0] alu_sel(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] r;
        r = ALU_ADD;
        unique case (f3)
            3'b000: r = alt ? ALU_SUB : ALU_ADD;
            3'b001: r = ALU_SLL;
            3'b010: r = ALU_SLT;
            3'b011: r = ALU_SLTU;
            3'b100: r = ALU_XOR;
            3'b101: r = alt ? ALU_SRA : ALU_SRL;
            3'b110: r = ALU_OR;
            3'b111: r = ALU_AND;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fmc_decoder.sv
// Combinational decode of the instruction register into ALU controls,
// an instruction class and the branch-taken outcome.
module fmc_decoder
    import fmc_pkg::*;
(
    input  logic [31:0] ir,
    input  logic        zero,
    input  logic        lsb,
    output logic [3:0]  alu_ctl,
    output logic        src_a,
    output logic        src_b,
    output iclass_t     cls,
    output logic        taken
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7b;
    logic       unused;

    assign opcode = ir[6:0];
    assign f3     = ir[14:12];
    assign f7b    = ir[30];
    assign unused = ^{ir[31], ir[29:15], ir[11:7]};

    always_comb begin
        alu_ctl = ALU_ADD;
        src_a   = 1'b1;
        src_b   = 1'b0;
        cls     = CL_ILL;
        taken   = 1'b0;
        unique case (1'b1)
            opcode == OP_R: begin
                cls     = CL_ALU;
                alu_ctl = alu_sel(f3, f7b);
            end
            opcode == OP_I: begin
                cls     = CL_ALU;
                src_b   = 1'b1;
                alu_ctl = alu_sel(f3, f7b && f3 == 3'b101);
            end
            opcode == OP_LD: begin
                cls   = CL_LOAD;
                src_b = 1'b1;
            end
            opcode == OP_ST: begin
                cls   = CL_STORE;
                src_b = 1'b1;
            end
            opcode == OP_BR: begin
                // funct3 010/011 have no branch meaning
                if (f3[2:1] != 2'b01) begin
                    cls     = CL_BRANCH;
                    alu_ctl = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT)
                                    : ALU_SUB;
                    taken   = (f3[2] ? lsb : zero) ^ f3[0];
                end
            end
            opcode == OP_JALR: begin
                cls   = CL_JUMP;
                src_b = 1'b1;
            end
            opcode == OP_JAL: begin
                cls   = CL_JUMP;
                src_a = 1'b0;
                src_b = 1'b1;
            end
            default: cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/fmc_controller.sv
// Multi-cycle sequencer: fetch, decode, dmem access, PC gating,
// handshake watchdog, trap state and retired-instruction counter.
module fmc_controller
    import fmc_pkg::*;
#(
    parameter int WAIT_LIMIT = 256,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    output logic             imem_req,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             zero,
    input  logic             LSb_aluresult,
    output logic [31:0]      instr,
    output logic             pc_en,
    output logic             regwrite,
    output logic             memtoreg,
    output logic             alusrcA,
    output logic             alusrcB,
    output logic [3:0]       aluControl,
    output logic             selBranch,
    output logic             jump,
    output logic             halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] instret
);

    localparam int WW = $clog2(WAIT_LIMIT) + 1;

    state_t        state, nxt;
    logic [31:0]   ir;
    logic [WW-1:0] wcnt;
    logic          berr;
    logic [3:0]    alu_ctl;
    logic          src_a, src_b, taken;
    iclass_t       cls;
    logic          tmo, stall, store;

    fmc_decoder u_dec (
        .ir      (ir),
        .zero    (zero),
        .lsb     (LSb_aluresult),
        .alu_ctl (alu_ctl),
        .src_a   (src_a),
        .src_b   (src_b),
        .cls     (cls),
        .taken   (taken)
    );

    assign tmo   = (wcnt == WW'(WAIT_LIMIT - 1));
    assign store = (cls == CL_STORE);
    assign stall = (state == ST_FETCH && !imem_ack)
                || (state == ST_MEM && !dmem_ack);

    always_comb begin
        nxt = state;
        unique case (state)
            ST_BOOT:  nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack)  nxt = ST_EXEC;
                else if (tmo)  nxt = ST_TRAP;
            end
            ST_EXEC: begin
                unique case (cls)
                    CL_LOAD, CL_STORE: nxt = ST_MEM;
                    CL_ILL:            nxt = ST_TRAP;
                    default:           nxt = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack)  nxt = ST_FETCH;
                else if (tmo)  nxt = ST_TRAP;
            end
            ST_TRAP:  nxt = ST_TRAP;
            default:  nxt = ST_TRAP;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state   <= ST_BOOT;
            ir      <= '0;
            wcnt    <= '0;
            berr    <= 1'b0;
            instret <= '0;
        end else begin
            state <= nxt;
            // counts only unacknowledged cycles of the current wait
            if (stall && nxt == state) wcnt <= wcnt + 1'b1;
            else                       wcnt <= '0;
            if (state == ST_FETCH && imem_ack) ir <= imem_rdata;
            if (stall && tmo) berr <= 1'b1;
            if (pc_en) instret <= instret + 1'b1;
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_en      = 1'b0;
        regwrite   = 1'b0;
        memtoreg   = 1'b0;
        alusrcA    = 1'b0;
        alusrcB    = 1'b0;
        aluControl = ALU_ADD;
        selBranch  = 1'b0;
        jump       = 1'b0;
        unique case (state)
            ST_FETCH: imem_req = 1'b1;
            ST_EXEC: begin
                if (cls != CL_ILL) begin
                    alusrcA    = src_a;
                    alusrcB    = src_b;
                    aluControl = alu_ctl;
                end
                unique case (cls)
                    CL_ALU: begin
                        regwrite = 1'b1;
                        pc_en    = 1'b1;
                    end
                    CL_BRANCH: begin
                        selBranch = taken;
                        pc_en     = 1'b1;
                    end
                    CL_JUMP: begin
                        jump  = 1'b1;
                        pc_en = 1'b1;
                    end
                    CL_LOAD, CL_STORE: begin
                        dmem_req = 1'b1;
                        dmem_we  = store;
                    end
                    default: pc_en = 1'b0;
                endcase
            end
            ST_MEM: begin
                alusrcA    = src_a;
                alusrcB    = src_b;
                aluControl = alu_ctl;
                dmem_req   = 1'b1;
                dmem_we    = store;
                pc_en      = dmem_ack;
                regwrite   = dmem_ack && !store;
                memtoreg   = dmem_ack && !store;
            end
            default: imem_req = 1'b0;
        endcase
    end

    assign instr     = ir;
    assign halted    = (state == ST_TRAP);
    assign bus_error = berr;

endmodule
